// File: rtl/btn_debounce_rst.sv
// Button conditioner: 2-flop sync, per-channel debounce, rise/fall pulses, stretched system reset.
// Latency: btn_q follows a clean input change DEB_CYCLES+2 edges later; pulses coincide with btn_q.
// Backpressure: none, free-running with one output update per clock.
module btn_debounce_rst #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int RST_BTN    = 0,
  parameter int RST_BTN_EN = 1,
  parameter int RST_HOLD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_q,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             sys_rst
);

  localparam int CNT_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic [N_BTN-1:0]  s1;
  logic [N_BTN-1:0]  s;
  logic [CNT_W-1:0]  cnt [N_BTN];
  logic [HOLD_W-1:0] hcnt;
  logic              rst_btn_hold;

  // Any sample matching the accepted level restarts the count, so bounce never accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s        <= '0;
      btn_q    <= '0;
      btn_rise <= '0;
      btn_fall <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1       <= btn_in;
      s        <= s1;
      btn_rise <= '0;
      btn_fall <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (s[i] == btn_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_q[i]    <= s[i];
          cnt[i]      <= '0;
          btn_rise[i] <= s[i];
          btn_fall[i] <= ~s[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rst_btn_hold = (RST_BTN_EN != 0) && btn_q[RST_BTN];

  // hcnt saturates at RST_HOLD; sys_rst drops on the edge that takes it there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt    <= '0;
      sys_rst <= 1'b1;
    end else if (rst_btn_hold) begin
      hcnt    <= '0;
      sys_rst <= 1'b1;
    end else if (hcnt != HOLD_MAX) begin
      hcnt <= hcnt + HOLD_W'(1);
      if (hcnt == HOLD_LAST) sys_rst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_debounce_rst.sv
// Scoreboard bench: stimulus queues expected output snapshots tagged with the clock edge at which
// they must appear; a negedge monitor pops one entry on every visible output change.
module tb_btn_debounce_rst;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_q;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;
  logic       sys_rst;

  btn_debounce_rst #(
    .N_BTN(4), .DEB_CYCLES(16), .RST_BTN(0), .RST_BTN_EN(1), .RST_HOLD(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_q(btn_q), .btn_rise(btn_rise), .btn_fall(btn_fall), .sys_rst(sys_rst)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       sr;
  } ev_t;

  ev_t exp_q[$];
  int  edge_cnt = 0;
  int  now      = 0;
  int  errors   = 0;
  int  checks   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic push(input int e, input logic [3:0] q, input logic [3:0] r,
                      input logic [3:0] f, input logic sr);
    ev_t ev;
    ev.edge_n = e; ev.q = q; ev.rise = r; ev.fall = f; ev.sr = sr;
    exp_q.push_back(ev);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
    now = edge_cnt;
  endtask

  // Monitor
  logic [12:0] prev;
  logic [12:0] cur;
  logic [12:0] want;
  bit          first = 1'b1;
  ev_t         e;

  always @(negedge clk) begin
    cur = {btn_q, btn_rise, btn_fall, sys_rst};
    while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: expected change at edge %0d, no output change observed (now edge %0d, outputs q=%b rise=%b fall=%b sys_rst=%b)",
               e.edge_n, edge_cnt, btn_q, btn_rise, btn_fall, sys_rst);
    end
    if (first || cur != prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d q=%b rise=%b fall=%b sys_rst=%b, required no change",
                 edge_cnt, btn_q, btn_rise, btn_fall, sys_rst);
      end else begin
        e = exp_q.pop_front();
        want = {e.q, e.rise, e.fall, e.sr};
        if (e.edge_n != edge_cnt || cur != want) begin
          errors++;
          $display("FAIL event: got edge %0d q=%b rise=%b fall=%b sys_rst=%b, required edge %0d q=%b rise=%b fall=%b sys_rst=%b",
                   edge_cnt, btn_q, btn_rise, btn_fall, sys_rst,
                   e.edge_n, e.q, e.rise, e.fall, e.sr);
        end
      end
    end
    prev  = cur;
    first = 1'b0;
  end

  initial begin
    rst    = 1'b0;
    btn_in = 4'b0000;
    #1 rst = 1'b1;
    // Reset state seen at the first sample
    push(1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(3);
    rst = 1'b0;
    push(now + 8, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(12);

    // Clean press on channel 2
    btn_in[2] = 1'b1;
    push(now + 18, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    push(now + 19, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    step(30);

    // Bouncing press on channel 1
    for (int k = 0; k < 2; k++) begin
      btn_in[1] = 1'b1;
      step(5);
      btn_in[1] = 1'b0;
      step(5);
    end
    btn_in[1] = 1'b1;
    push(now + 18, 4'b0110, 4'b0010, 4'b0000, 1'b0);
    push(now + 19, 4'b0110, 4'b0000, 4'b0000, 1'b0);
    step(30);

    // Short glitch on channel 3 must produce no output change
    btn_in[3] = 1'b1;
    step(10);
    btn_in[3] = 1'b0;
    step(30);

    // Reset button on channel 0
    btn_in[0] = 1'b1;
    push(now + 18, 4'b0111, 4'b0001, 4'b0000, 1'b0);
    push(now + 19, 4'b0111, 4'b0000, 4'b0000, 1'b1);
    step(40);
    btn_in[0] = 1'b0;
    push(now + 18, 4'b0110, 4'b0000, 4'b0001, 1'b1);
    push(now + 19, 4'b0110, 4'b0000, 4'b0000, 1'b1);
    push(now + 26, 4'b0110, 4'b0000, 4'b0000, 1'b0);
    step(40);

    // Release channels 1 and 2 together
    btn_in[2:1] = 2'b00;
    push(now + 18, 4'b0000, 4'b0000, 4'b0110, 1'b0);
    push(now + 19, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(30);

    // rst in the middle of a debounce count (cnt=9 on channel 2)
    btn_in[2] = 1'b1;
    step(11);
    push(now, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    push(now + 8, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(now + 18, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    push(now + 19, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    step(30);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
